target_port: RTL

// Slave-side bus port. It receives the 1-bit serial stream from an initiator port: a 16-bit address LSB-first (bus_mode=0), then 8 write-data bits LSB-first (bus_mode=1).
// It turns each transfer into one memory-side request. For reads it serializes the 8-bit read data back onto the bus. It pulses s_ack to close every accepted transfer.

---
 rtl/target_port.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/target_port.sv
// target_port: slave side of the 1-bit serial bus.
// Receives a serial address (and write data), issues one memory request per
// transfer, serializes read data back to the initiator and pulses s_ack.
// Optional address decode is enabled by defining TARGET_ADDR_DECODE_EN.
module target_port #(
    parameter int                ADDR_W     = 16,
    parameter int                DATA_W     = 8,
    parameter int                MEM_ADDR_W = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  bus_data_in,
    input  logic                  bus_data_in_valid,
    input  logic                  bus_mode,
    input  logic                  bus_m_rw,
    input  logic                  bus_m_ready,
    output logic                  bus_data_out,
    output logic                  bus_data_out_valid,
    output logic                  s_ack,
    output logic                  busy,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int ACW   = $clog2(ADDR_W);
    localparam int DCW   = $clog2(DATA_W);
    localparam int CNT_W = (ACW > DCW) ? ACW : DCW;

    typedef enum logic [3:0] {
        IDLE, ADDR, DATA, MEM_WR, MEM_RD, RD_WAIT, WAIT_RDY, TX, ACK
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic                  rw_q, rw_d;
    logic                  miss_q, miss_d;
    logic                  miss_now;

    // State and datapath registers, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            mem_addr_q <= '0;
            rw_q       <= 1'b0;
            miss_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            mem_addr_q <= mem_addr_d;
            rw_q       <= rw_d;
            miss_q     <= miss_d;
        end
    end

    // Next-state logic: serial capture, memory handshake and read serialization
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        mem_addr_d = mem_addr_q;
        rw_d       = rw_q;
        miss_d     = miss_q;
        miss_now   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus_data_in_valid && !bus_mode) begin
                    addr_d[0] = bus_data_in;
                    cnt_d     = CNT_W'(1);
                    miss_d    = 1'b0;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (bus_data_in_valid) begin
                    addr_d[cnt_q[ACW-1:0]] = bus_data_in;
                    if (cnt_q == CNT_W'(ADDR_W - 1)) begin
`ifdef TARGET_ADDR_DECODE_EN
                        miss_now = (addr_d[ADDR_W-1:MEM_ADDR_W] !=
                                    BASE_ADDR[ADDR_W-1:MEM_ADDR_W]);
`else
                        miss_now = 1'b0;
`endif
                        rw_d   = bus_m_rw;
                        cnt_d  = '0;
                        miss_d = miss_now;
                        if (bus_m_rw) begin
                            state_d = DATA;
                        end else if (miss_now) begin
                            state_d = IDLE;
                        end else begin
                            mem_addr_d = addr_d[MEM_ADDR_W-1:0];
                            state_d    = MEM_RD;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DATA: begin
                if (bus_data_in_valid) begin
                    if (!bus_mode) begin
                        addr_d[0] = bus_data_in;
                        cnt_d     = CNT_W'(1);
                        miss_d    = 1'b0;
                        state_d   = ADDR;
                    end else begin
                        wdata_d[cnt_q[DCW-1:0]] = bus_data_in;
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            cnt_d = '0;
                            if (miss_q) begin
                                state_d = IDLE;
                            end else begin
                                mem_addr_d = addr_q[MEM_ADDR_W-1:0];
                                state_d    = MEM_WR;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            MEM_WR: begin
                if (mem_gnt) state_d = ACK;
            end
            MEM_RD: begin
                if (mem_gnt) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (mem_rvalid) begin
                    rdata_d = mem_rdata;
                    cnt_d   = '0;
                    state_d = bus_m_ready ? TX : WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if (bus_m_ready) begin
                    cnt_d   = '0;
                    state_d = TX;
                end
            end
            TX: begin
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    cnt_d   = '0;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decoded from the registered state so they are all zero after reset
    always_comb begin
        busy               = (state_q != IDLE);
        s_ack              = (state_q == ACK);
        mem_req            = (state_q == MEM_WR) || (state_q == MEM_RD);
        mem_we             = mem_req && rw_q;
        mem_addr           = mem_req ? mem_addr_q : '0;
        mem_wdata          = (state_q == MEM_WR) ? wdata_q : '0;
        bus_data_out_valid = (state_q == TX);
        bus_data_out       = (state_q == TX) ? rdata_q[cnt_q[DCW-1:0]] : 1'b0;
    end

`ifndef TARGET_ADDR_DECODE_EN
    // Upper address bits and the decode base only matter when decoding is on
    logic unused_decode;
    assign unused_decode = ^{addr_q[ADDR_W-1:MEM_ADDR_W], BASE_ADDR};
`endif

endmodule
